// File: rtl/esc_pwm_gen.sv
// ---------------------------------------------------------------------------
// esc_pwm_gen
//
// Per-motor ESC pulse generator. Turns an 11-bit speed into a fixed-rate
// servo-style pulse. The default parameters give a 400 Hz frame at 50 MHz,
// a 1 ms pulse at speed 0 and about 2 ms at speed 2047.
//
// A new speed passes through a three-stage width pipeline:
//   capture -> scale -> offset/saturate
// The result is held as a pending width. It is only promoted to the live
// width on the last cycle of a frame, so a pulse is never cut short or
// stretched part-way through.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   wrt          one-cycle strobe: capture SPEED
//   SPEED[10:0]  requested speed, 0..2047
//   PWM          registered ESC pulse output
//   frame_start  one-cycle pulse on the first cycle of each frame (cnt == 0)
//   pulse_cyc    width in cycles of the frame currently being output
//
// Optional feature (macro SLEW_LIMIT_EN):
//   When defined, each frame boundary moves pulse_cyc toward the pending
//   width by at most MAX_STEP cycles. The pending width stays valid until
//   it is reached. When undefined, the width jumps in one boundary, and
//   neither the MAX_STEP parameter nor any slew hardware exists.
// ---------------------------------------------------------------------------
module esc_pwm_gen #(
    parameter int PERIOD_CYC = 125000,
    parameter int MIN_PULSE  = 50000,
    parameter int SPD_SCALE  = 25
`ifdef SLEW_LIMIT_EN
    ,
    parameter int MAX_STEP   = 2000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [10:0] SPEED,
    output logic        PWM,
    output logic        frame_start,
    output logic [16:0] pulse_cyc
);

    localparam logic [16:0] LAST_CNT = 17'(PERIOD_CYC - 1);
    localparam logic [16:0] MIN_W    = 17'(MIN_PULSE);
    localparam logic [16:0] SCALE_W  = 17'(SPD_SCALE);

    // Frame counter and output registers
    logic [16:0] cnt_q, cnt_d;
    logic        pwm_q, pwm_d;
    logic        frame_start_q, frame_start_d;
    logic        at_boundary;

    // Width pipeline registers
    logic [10:0] spd_q, spd_d;
    logic        spd_valid_q, spd_valid_d;
    logic [16:0] prod_q, prod_d;
    logic        prod_valid_q, prod_valid_d;
    logic [16:0] pulse_pend_q, pulse_pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic [16:0] pulse_cyc_q, pulse_cyc_d;

    // Stage-3 sum is one bit wider so an overflowing parameter set saturates
    // instead of wrapping.
    logic [17:0] width_sum;

    // Free-running frame counter, 0 .. PERIOD_CYC-1.
    // The last count is the frame boundary.
    always_comb begin
        at_boundary = (cnt_q == LAST_CNT);
        cnt_d       = at_boundary ? 17'd0 : cnt_q + 17'd1;
    end

    // Width pipeline.
    // Each stage carries its own valid bit, so only a real write reaches
    // the pending width. A strobe held high keeps recapturing SPEED, and the
    // last captured value is the one that arrives last.
    always_comb begin
        spd_d        = wrt ? SPEED : spd_q;
        spd_valid_d  = wrt;

        prod_d       = spd_valid_q ? ({6'd0, spd_q} * SCALE_W) : prod_q;
        prod_valid_d = spd_valid_q;

        width_sum    = {1'b0, prod_q} + {1'b0, MIN_W};
        pulse_pend_d = pulse_pend_q;
        if (prod_valid_q) begin
            if (width_sum > {1'b0, LAST_CNT}) begin
                pulse_pend_d = LAST_CNT;
            end else begin
                pulse_pend_d = width_sum[16:0];
            end
        end
    end

`ifdef SLEW_LIMIT_EN
    localparam logic [16:0] STEP_W = 17'(MAX_STEP);

    // Next live width when ramping: the pending width if it is within one
    // step, otherwise one step from the current width in its direction.
    logic [16:0] slew_target;

    always_comb begin
        slew_target = pulse_pend_q;
        if (pulse_pend_q > pulse_cyc_q) begin
            if ((pulse_pend_q - pulse_cyc_q) > STEP_W) begin
                slew_target = pulse_cyc_q + STEP_W;
            end
        end else begin
            if ((pulse_cyc_q - pulse_pend_q) > STEP_W) begin
                slew_target = pulse_cyc_q - STEP_W;
            end
        end
    end
`endif

    // Frame-boundary promotion of the pending width.
    // A stage-3 result that lands on the boundary cycle itself is a write
    // for the following frame. Its set therefore overrides the clear, and
    // the new value stays pending.
    always_comb begin
        pulse_cyc_d  = pulse_cyc_q;
        pend_valid_d = pend_valid_q;
        if (at_boundary && pend_valid_q) begin
`ifdef SLEW_LIMIT_EN
            pulse_cyc_d = slew_target;
            if (slew_target == pulse_pend_q) begin
                pend_valid_d = 1'b0;
            end
`else
            pulse_cyc_d  = pulse_pend_q;
            pend_valid_d = 1'b0;
`endif
        end
        if (prod_valid_q) begin
            pend_valid_d = 1'b1;
        end
    end

    // The output compare uses next-cycle values, so PWM is a flop. It rises
    // together with frame_start and stays high for exactly pulse_cyc cycles.
    always_comb begin
        frame_start_d = (cnt_d == 17'd0);
        pwm_d         = (cnt_d < pulse_cyc_d);
    end

    // State registers.
    // Reset loads the minimum width directly. The first frame is therefore
    // the zero-throttle arming pulse, and any pending width is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= 17'd0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
            spd_q         <= 11'd0;
            spd_valid_q   <= 1'b0;
            prod_q        <= 17'd0;
            prod_valid_q  <= 1'b0;
            pulse_pend_q  <= MIN_W;
            pend_valid_q  <= 1'b0;
            pulse_cyc_q   <= MIN_W;
        end else begin
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            spd_q         <= spd_d;
            spd_valid_q   <= spd_valid_d;
            prod_q        <= prod_d;
            prod_valid_q  <= prod_valid_d;
            pulse_pend_q  <= pulse_pend_d;
            pend_valid_q  <= pend_valid_d;
            pulse_cyc_q   <= pulse_cyc_d;
        end
    end

    assign PWM         = pwm_q;
    assign frame_start = frame_start_q;
    assign pulse_cyc   = pulse_cyc_q;

endmodule

// File: doc/esc_pwm_gen.md
Name: esc_pwm_gen

Overview:
- Per-motor ESC pulse generator. It sits directly downstream of the four-motor ESC wrapper; the wrapper instantiates one per motor and drives SPEED with an 11-bit speed that is already forced to zero on motors_off.
- Converts the written speed into a fixed-rate servo-style PWM: 1 ms minimum pulse, about 2 ms maximum, 400 Hz frame at 50 MHz.
- New speeds are double-buffered so a pulse width only changes at a frame boundary. The block never emits a truncated or stretched pulse.

Parameters:
- PERIOD_CYC, 125000: frame length in clk cycles (400 Hz at 50 MHz).
- MIN_PULSE, 50000: pulse width in cycles for SPEED = 0 (1 ms).
- SPD_SCALE, 25: cycles added per SPEED LSB. SPEED = 2047 gives 101175 cycles.
- MAX_STEP, 2000: maximum width change per frame in cycles. Used only with SLEW_LIMIT_EN.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- wrt, input, 1: one-cycle strobe; capture SPEED.
- SPEED, input, 11: requested speed, unsigned 0..2047.
- PWM, output, 1: ESC pulse output, registered.
- frame_start, output, 1: one-cycle pulse on the first cycle of each frame (cnt == 0).
- pulse_cyc, output, 17: pulse width of the frame currently being output, in cycles.

Behaviour:
- Reset (asynchronous assert on rst high, synchronous release):
  - PWM = 0, frame_start = 0, cnt = 0.
  - spd_q = 0, pend_valid = 0.
  - pulse_cyc = MIN_PULSE, pulse_pend = MIN_PULSE.
  - The first frame after reset outputs a MIN_PULSE-wide pulse, which is the zero-throttle arming pulse.
- Frame counter: 17-bit cnt counts 0..PERIOD_CYC-1 and then wraps to 0. It free-runs and is not affected by wrt.
- Width pipeline (3 stages):
  - Stage 1: on wrt, spd_q <= SPEED.
  - Stage 2: prod <= spd_q * SPD_SCALE, unsigned, 17 bits.
  - Stage 3: pulse_pend <= prod + MIN_PULSE, and pend_valid <= 1.
  - Stage 3 result is saturated to PERIOD_CYC-1 if the parameters would overflow; with the defaults this never triggers.
- Frame boundary (cycle where cnt == PERIOD_CYC-1):
  - If pend_valid: pulse_cyc <= pulse_pend and pend_valid <= 0.
  - Otherwise pulse_cyc holds its value.
- Latency and ordering:
  - A wrt at cycle t makes pulse_pend valid at t+3.
  - If the frame boundary falls at t, t+1 or t+2, the new value is applied at the following boundary.
  - Multiple wrt strobes within one frame: the last one wins.
  - A wrt that coincides with the boundary cycle is treated as a write after the boundary.
  - A pend_valid set and a boundary clear landing on the same cycle resolve in favour of set: the new value stays pending.
- PWM timing:
  - PWM is a registered compare: PWM <= (cnt_next < pulse_cyc_next).
  - This makes PWM rise on the cycle frame_start is asserted and stay high for exactly pulse_cyc cycles.
- frame_start is registered and aligned with the cycle cnt == 0.
- wrt held high for several cycles: SPEED is recaptured every cycle; the last value wins.
- Reset mid-frame: PWM drops to 0 immediately (asynchronous) and any pending width is discarded.
- SPEED values outside 0..2047 are impossible by width. SPEED = 0 is legal and yields MIN_PULSE.

Optional Feature:
- Macro: SLEW_LIMIT_EN.
- Defined: at each frame boundary, pulse_cyc moves toward pulse_pend by at most MAX_STEP cycles.
  - pend_valid stays set until pulse_cyc equals pulse_pend.
  - Write-down and write-up are symmetric.
  - Reset still loads MIN_PULSE directly, with no ramp.
- Undefined: pulse_cyc jumps to pulse_pend in a single boundary. No slew logic or MAX_STEP comparator is present.

Test Plan:
- Release rst, no wrt -> every frame PWM high for 50000 cycles, period 125000 cycles; frame_start pulses every 125000 cycles; pulse_cyc = 50000.
- wrt with SPEED = 2047 mid-frame -> current frame unchanged; next frame PWM high for 101175 cycles; pulse_cyc = 101175.
- wrt with SPEED = 1000 at cnt = 124998 (3-stage latency crosses the boundary) -> next frame still at the old width; the frame after is 75000 cycles.
- Three wrt strobes in one frame (SPEED = 100, 500, 40) -> next frame width 51000 only; no intermediate widths appear.
- Assert rst at cnt = 30000 while PWM is high -> PWM = 0 the same cycle; after release, first frame width 50000 and the pending write is discarded.
- With SLEW_LIMIT_EN: SPEED 0 -> 2047 -> widths 52000, 54000, ..., 100000, then 101175 on successive frames, 26 frames total.
